// File: rtl/snake_frame_builder.sv
// Snake-game frame rasteriser: snapshots food and body positions on start, draws
// them one point per cycle into a back buffer, then swaps it onto the LED frame.
module snake_frame_builder #(
  parameter  int GRID_W  = 16,
  parameter  int GRID_H  = 16,
  parameter  int COORD_W = 4,
  parameter  int MAX_LEN = 10,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [2*COORD_W-1:0]           i_food,
  input  logic [LEN_W-1:0]               i_snake_len,
  input  logic [MAX_LEN*2*COORD_W-1:0]   i_snake_pos,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [GRID_W*GRID_H-1:0]       o_frame,
  output logic                           o_hit_self,
  output logic                           o_ate_food,
  output logic                           o_oob
);
  localparam int PW   = 2 * COORD_W;
  localparam int NPIX = GRID_W * GRID_H;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_SWAP} state_t;

  state_t                      r_state, w_next;
  logic [PW-1:0]               r_food;
  logic [MAX_LEN-1:0][PW-1:0]  r_seg;
  logic [LEN_W-1:0]            r_len, r_idx;
  logic [NPIX-1:0]             r_back;
  logic                        r_hit, r_ate, r_oob;

  logic [PW-1:0]               w_pt;
  logic [COORD_W-1:0]          w_x, w_y;
  logic                        w_inrange;
  logic [AW-1:0]               w_addr;
  logic [LEN_W-1:0]            w_len_clamp;

  assign o_busy      = (r_state != S_IDLE);
  assign w_len_clamp = (i_snake_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_snake_len;

  // idx 0 is the food, idx k is segment k-1
  always_comb begin
    w_pt = r_food;
    for (int k = 0; k < MAX_LEN; k++)
      if (r_idx == LEN_W'(k + 1)) w_pt = r_seg[k];
  end

  assign w_x       = w_pt[COORD_W-1:0];
  assign w_y       = w_pt[PW-1:COORD_W];
  assign w_inrange = ({1'b0, w_x} < (COORD_W+1)'(GRID_W)) &&
                     ({1'b0, w_y} < (COORD_W+1)'(GRID_H));
  assign w_addr    = AW'(int'(w_y) * GRID_W + int'(w_x));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_DRAW;
      S_DRAW:  if (r_idx == r_len) w_next = S_SWAP;
      S_SWAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_food     <= '0;
      r_seg      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_back     <= '0;
      r_hit      <= 1'b0;
      r_ate      <= 1'b0;
      r_oob      <= 1'b0;
      o_done     <= 1'b0;
      o_frame    <= '0;
      o_hit_self <= 1'b0;
      o_ate_food <= 1'b0;
      o_oob      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_food <= i_food;
          r_seg  <= i_snake_pos;
          r_len  <= w_len_clamp;
        end
        S_CLEAR: begin
          r_back <= '0;
          r_idx  <= '0;
          r_hit  <= 1'b0;
          r_ate  <= 1'b0;
          r_oob  <= 1'b0;
        end
        S_DRAW: begin
          if (w_inrange) r_back[w_addr] <= 1'b1;
          else           r_oob <= 1'b1;
          if (r_idx == '0 && r_len != '0 && r_food == r_seg[0]) r_ate <= 1'b1;
          if (r_idx >= LEN_W'(2) && w_pt == r_seg[0])           r_hit <= 1'b1;
          if (r_idx != r_len) r_idx <= r_idx + 1'b1;
        end
        S_SWAP: begin
          o_frame    <= r_back;
          o_hit_self <= r_hit;
          o_ate_food <= r_ate;
          o_oob      <= r_oob;
          o_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_frame_builder.sv
// Randomised bench for snake_frame_builder: a 16x16 and a 12x8 instance share the
// same stimulus and are compared against a point-list reference model.
module tb_snake_frame_builder;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [7:0]   food;
  logic [3:0]   len;
  logic [79:0]  pos;
  logic         busy_a, done_a, hit_a, ate_a, oob_a;
  logic [255:0] frame_a;
  logic         busy_b, done_b, hit_b, ate_b, oob_b;
  logic [95:0]  frame_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] s_food;
  logic [7:0] s_seg [10];
  int         s_len;

  always #5 clk = ~clk;

  snake_frame_builder u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_food(food), .i_snake_len(len),
    .i_snake_pos(pos), .o_busy(busy_a), .o_done(done_a), .o_frame(frame_a),
    .o_hit_self(hit_a), .o_ate_food(ate_a), .o_oob(oob_a));

  snake_frame_builder #(.GRID_W(12), .GRID_H(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_food(food), .i_snake_len(len),
    .i_snake_pos(pos), .o_busy(busy_b), .o_done(done_b), .o_frame(frame_b),
    .o_hit_self(hit_b), .o_ate_food(ate_b), .o_oob(oob_b));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: list of points (food, then the first L segments), each plotted if on grid.
  function automatic void model(input int gw, input int gh, output logic [255:0] f,
                                output logic h, output logic a, output logic o);
    int L, x, y;
    logic [7:0] pts [11];
    L = (s_len > 10) ? 10 : s_len;
    f = '0; h = 1'b0; o = 1'b0;
    pts[0] = s_food;
    for (int k = 0; k < L; k++) pts[k+1] = s_seg[k];
    for (int k = 0; k <= L; k++) begin
      x = int'(pts[k][3:0]);
      y = int'(pts[k][7:4]);
      if (x < gw && y < gh) f[y*gw + x] = 1'b1;
      else o = 1'b1;
    end
    a = (L >= 1) && (s_food == s_seg[0]);
    for (int k = 1; k < L; k++) if (s_seg[k] == s_seg[0]) h = 1'b1;
  endfunction

  task automatic apply();
    food = s_food;
    len  = 4'(s_len);
    for (int k = 0; k < 10; k++) pos[k*8 +: 8] = s_seg[k];
  endtask

  task automatic rand_stim();
    s_seg[0] = 8'($urandom);
    for (int k = 1; k < 10; k++)
      s_seg[k] = ($urandom_range(0, 4) == 0) ? s_seg[0] : 8'($urandom);
    s_food = ($urandom_range(0, 3) == 0) ? s_seg[0] : 8'($urandom);
    s_len  = $urandom_range(0, 15);
  endtask

  // pre: start already driven at the previous done cycle.
  task automatic run(input bit pre, input bit disturb, input bit chain);
    logic [255:0] ef_a, ef_b;
    logic eh_a, ea_a, eo_a, eh_b, ea_b, eo_b;
    int L, nb, lat, extra;
    if (!pre) begin
      @(negedge clk); apply(); start = 1'b1;
    end
    L = (s_len > 10) ? 10 : s_len;
    model(16, 16, ef_a, eh_a, ea_a, eo_a);
    model(12, 8, ef_b, eh_b, ea_b, eo_b);
    @(negedge clk); start = 1'b0;
    nb = int'(busy_a); lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (disturb && c == 2) start = 1'b1;
      if (disturb && c == 3) begin
        start = 1'b0;
        pos = {$urandom, $urandom, 16'($urandom)};
        food = 8'($urandom);
        len = 4'($urandom);
      end
      if (done_a) begin lat = c; break; end
      nb += int'(busy_a);
    end
    check("latency", 256'(lat), 256'(L + 3));
    check("busy_cycles", 256'(nb), 256'(L + 3));
    check("done_b", 256'(done_b), 256'(1));
    check("frame_a", frame_a, ef_a);
    check("flags_a", 256'({hit_a, ate_a, oob_a}), 256'({eh_a, ea_a, eo_a}));
    check("frame_b", 256'(frame_b), ef_b);
    check("flags_b", 256'({hit_b, ate_b, oob_b}), 256'({eh_b, ea_b, eo_b}));
    if (chain) begin
      rand_stim(); apply(); start = 1'b1;
    end else begin
      @(negedge clk);
      check("done_pulse", 256'(done_a), 256'(0));
      check("frame_hold", frame_a, ef_a);
    end
    if (disturb) begin
      extra = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk); extra += int'(done_a);
      end
      check("no_extra_done", 256'(extra), 256'(0));
    end
  endtask

  initial begin
    int extra, chg;
    rst = 1'b1; start = 1'b0; food = '0; len = '0; pos = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_frame", frame_a, 256'(0));
    check("rst_ctl", 256'({done_a, busy_a, hit_a, ate_a, oob_a}), 256'(0));
    rst = 1'b0;
    chg = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chg += int'(frame_a != '0) + int'(done_a) + int'(busy_a) + int'(hit_a | ate_a | oob_a);
    end
    check("idle_stable", 256'(chg), 256'(0));

    // Basic draw
    s_food = 8'h35; s_len = 3;
    foreach (s_seg[k]) s_seg[k] = 8'hFF;
    s_seg[0] = 8'h00; s_seg[1] = 8'h01; s_seg[2] = 8'h02;
    run(0, 0, 0);
    check("basic_bits", frame_a, (256'(1) << 53) | 256'h7);

    // Eat + self-hit
    s_food = 8'h44; s_len = 4;
    for (int k = 0; k < 4; k++) s_seg[k] = 8'h44;
    run(0, 0, 0);
    check("eat_hit", 256'({ate_a, hit_a}), 256'(2'b11));
    check("eat_ones", 256'($countones(frame_a)), 256'(1));

    // Clamp: 10 distinct segments
    s_food = 8'hEE; s_len = 15;
    for (int k = 0; k < 10; k++) s_seg[k] = 8'(k * 17);
    run(0, 0, 0);
    check("clamp_ones", 256'($countones(frame_a)), 256'(11));

    // L = 0
    s_food = 8'h44; s_len = 0;
    run(0, 0, 0);

    // Out-of-range on the 12x8 grid, then all in range
    s_food = 8'h93; s_len = 3;
    s_seg[0] = 8'h21; s_seg[1] = 8'h22; s_seg[2] = 8'h23;
    run(0, 0, 0);
    check("oob_set", 256'({oob_b, oob_a}), 256'(2'b10));
    s_food = 8'h55; s_seg[0] = 8'h0B; s_seg[1] = 8'h71; s_seg[2] = 8'h7B;
    run(0, 0, 0);
    check("oob_clear", 256'(oob_b), 256'(0));

    // Busy start ignored, inputs changed mid-build
    rand_stim(); s_len = 8;
    run(0, 1, 0);

    // Back-to-back frames
    rand_stim();
    run(0, 0, 1);
    run(1, 0, 1);
    run(1, 0, 0);

    // Reset during DRAW
    s_food = 8'h12; s_len = 6;
    for (int k = 0; k < 10; k++) s_seg[k] = 8'(8'h30 + k);
    @(negedge clk); apply(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_frame", frame_a, 256'(0));
    check("mid_rst_ctl", 256'({done_a, busy_a, hit_a, ate_a, oob_a, busy_b}), 256'(0));
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); extra += int'(done_a);
    end
    check("mid_rst_nodone", 256'(extra), 256'(0));
    run(0, 0, 0);

    // Random frames
    for (int t = 0; t < 40; t++) begin
      rand_stim();
      run(0, 0, t[2]);
      if (t[2]) run(1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
